// File: rtl/frame_tx_if.sv
// Handshake and serial-output bundle for frame_tx.
// master drives strobe and payload; slave is the transmitter.
interface frame_tx_if #(
  parameter int unsigned DATA_W = 8
);
  logic              strb;
  logic [DATA_W-1:0] din;
  logic              din_valid;
  logic              din_ready;
  logic              sdo;
  logic              sdo_en;
  logic              underrun;
  logic              frame_err;
  logic              lock;

  modport master (
    output strb, din, din_valid,
    input  din_ready, sdo, sdo_en, underrun, frame_err, lock
  );

  modport slave (
    input  strb, din, din_valid,
    output din_ready, sdo, sdo_en, underrun, frame_err, lock
  );
endinterface

// File: rtl/frame_tx.sv
// Strobe-triggered MSB-first serial frame transmitter with strobe period lock detection.
// Optional trailing even-parity bit when FRAME_PARITY_EN is defined.
module frame_tx #(
  parameter int unsigned FRAME_LEN = 256,
  parameter int unsigned DATA_W    = 8
) (
  input logic       clk,
  input logic       rst_n,
  frame_tx_if.slave bus
);

  localparam int unsigned CntW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [1:0] {
    StIdle,
    StShift
`ifdef FRAME_PARITY_EN
    , StPar
`endif
  } state_e;

  state_e            state_q, state_d;
  logic              strb_d;
  logic              armed_q;
  logic [DATA_W-1:0] hold_q;
  logic              hold_full_q;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [CntW-1:0]   bcnt_q, bcnt_d;
  logic [15:0]       per_cnt_q;
  logic              first_q;
  logic [1:0]        good_q;
  logic              lock_q;
  logic              underrun_q;
  logic              frame_err_q;
  logic              start;
  logic              load;
  logic              accept;
  logic              period_ok;
  logic              sdo;
  logic              sdo_en;
`ifdef FRAME_PARITY_EN
  logic              par_q;
`endif

  // armed_q masks the first clock after reset so a strobe already high is not an edge.
  assign start     = bus.strb & ~strb_d & armed_q;
  assign accept    = bus.din_valid & ~hold_full_q;
  assign period_ok = (per_cnt_q == 16'(FRAME_LEN));

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bcnt_d  = bcnt_q;
    load    = 1'b0;
    sdo     = 1'b0;
    sdo_en  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StShift;
          load    = 1'b1;
          shift_d = hold_full_q ? hold_q : '0;
          bcnt_d  = CntW'(DATA_W - 1);
        end
      end
      StShift: begin
        sdo     = shift_q[DATA_W-1];
        sdo_en  = 1'b1;
        shift_d = shift_q << 1;
        bcnt_d  = bcnt_q - 1'b1;
        if (bcnt_q == '0) begin
`ifdef FRAME_PARITY_EN
          state_d = StPar;
`else
          state_d = StIdle;
`endif
        end
      end
`ifdef FRAME_PARITY_EN
      StPar: begin
        sdo     = par_q;
        sdo_en  = 1'b1;
        state_d = StIdle;
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      shift_q     <= '0;
      bcnt_q      <= '0;
      strb_d      <= 1'b0;
      armed_q     <= 1'b0;
      underrun_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      bcnt_q      <= bcnt_d;
      strb_d      <= bus.strb;
      armed_q     <= 1'b1;
      underrun_q  <= load & ~hold_full_q;
      frame_err_q <= start & (state_q != StIdle);
    end
  end

`ifdef FRAME_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_q <= 1'b0;
    end else if (load) begin
      par_q <= ^shift_d;
    end
  end
`endif

  // A load can only coincide with an accept when hold was empty, so accept wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q      <= '0;
      hold_full_q <= 1'b0;
    end else if (accept) begin
      hold_q      <= bus.din;
      hold_full_q <= 1'b1;
    end else if (load) begin
      hold_full_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      per_cnt_q <= '0;
      first_q   <= 1'b1;
      good_q    <= '0;
    end else if (start) begin
      per_cnt_q <= 16'd1;
      first_q   <= 1'b0;
      if (!first_q) begin
        if (!period_ok) begin
          good_q <= '0;
        end else if (good_q != 2'd2) begin
          good_q <= good_q + 2'd1;
        end
      end
    end else if (per_cnt_q != 16'hFFFF) begin
      per_cnt_q <= per_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_q <= 1'b0;
    end else if (start && !first_q && !period_ok) begin
      lock_q <= 1'b0;
    end else if (good_q == 2'd2) begin
      lock_q <= 1'b1;
    end
  end

  assign bus.din_ready = ~hold_full_q;
  assign bus.sdo       = sdo;
  assign bus.sdo_en    = sdo_en;
  assign bus.underrun  = underrun_q;
  assign bus.frame_err = frame_err_q;
  assign bus.lock      = lock_q;

endmodule

// File: tb/tb_frame_tx.sv
// Directed bench for frame_tx: payload shifting, underrun, frame error, lock and reset.
module tb_frame_tx;

`ifdef FRAME_PARITY_EN
  localparam int NBITS = 9;
`else
  localparam int NBITS = 8;
`endif

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  frame_tx_if #(.DATA_W(8)) bus ();

  frame_tx #(
    .FRAME_LEN(256),
    .DATA_W   (8)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic write_word(input logic [7:0] w);
    bus.din       = w;
    bus.din_valid = 1'b1;
    tick();
    bus.din_valid = 1'b0;
    check_eq("ready_after_write", 32'(bus.din_ready), 32'd0);
  endtask

  // Raises strb now and checks the whole frame. restrobe >= 0 re-raises strb mid-frame.
  // held: din_valid stays high with a second word pending in the bus.
  task automatic run_frame(input logic [7:0] data, input logic exp_ur, input int restrobe,
                           input logic held);
    logic exp_bit;
    bus.strb = 1'b1;
    for (int i = 0; i < NBITS; i++) begin
      tick();
      exp_bit = (i < 8) ? data[7-i] : ^data;
      check_eq($sformatf("sdo_en[%0d]", i), 32'(bus.sdo_en), 32'd1);
      check_eq($sformatf("sdo[%0d]", i), 32'(bus.sdo), 32'(exp_bit));
      if (i == 0) begin
        check_eq("underrun", 32'(bus.underrun), 32'(exp_ur));
        check_eq("ready_after_load", 32'(bus.din_ready), 32'd1);
        check_eq("frame_err_idle", 32'(bus.frame_err), 32'd0);
      end
      if (i == 1) begin
        check_eq("underrun_gone", 32'(bus.underrun), 32'd0);
        check_eq("ready_second", 32'(bus.din_ready), held ? 32'd0 : 32'd1);
        bus.din_valid = 1'b0;
        bus.strb      = 1'b0;
      end
      if (restrobe >= 0 && i == restrobe) bus.strb = 1'b1;
      if (restrobe >= 0 && i == restrobe + 1) begin
        check_eq("frame_err", 32'(bus.frame_err), 32'd1);
        bus.strb = 1'b0;
      end
      if (restrobe >= 0 && i == restrobe + 2) begin
        check_eq("frame_err_pulse", 32'(bus.frame_err), 32'd0);
      end
    end
    tick();
    check_eq("sdo_en_end", 32'(bus.sdo_en), 32'd0);
    check_eq("sdo_end", 32'(bus.sdo), 32'd0);
  endtask

  // Raise strb, keep it high 3 clocks, return exactly gap clocks after the raise.
  task automatic edge_gap(input int gap);
    bus.strb = 1'b1;
    for (int i = 0; i < gap; i++) begin
      tick();
      if (i == 2) bus.strb = 1'b0;
    end
  endtask

  task automatic do_reset(input logic strb_level);
    rst_n    = 1'b0;
    bus.strb = strb_level;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    rst_n         = 1'b1;
    bus.strb      = 1'b0;
    bus.din       = '0;
    bus.din_valid = 1'b0;
    tick();

    // Reset with strb held high: no frame on release.
    do_reset(1'b1);
    check_eq("rst_ready", 32'(bus.din_ready), 32'd1);
    check_eq("rst_sdo", 32'(bus.sdo), 32'd0);
    check_eq("rst_sdo_en", 32'(bus.sdo_en), 32'd0);
    check_eq("rst_underrun", 32'(bus.underrun), 32'd0);
    check_eq("rst_frame_err", 32'(bus.frame_err), 32'd0);
    check_eq("rst_lock", 32'(bus.lock), 32'd0);
    tick();
    tick();
    check_eq("strb_high_at_release", 32'(bus.sdo_en), 32'd0);
    bus.strb = 1'b0;
    tick();

    write_word(8'hA5);
    run_frame(8'hA5, 1'b0, -1, 1'b0);

    run_frame(8'h00, 1'b1, -1, 1'b0);

    write_word(8'h3C);
    run_frame(8'h3C, 1'b0, 3, 1'b0);

    // Back-to-back words with din_valid held.
    bus.din       = 8'h01;
    bus.din_valid = 1'b1;
    tick();
    check_eq("held_accept1", 32'(bus.din_ready), 32'd0);
    bus.din = 8'h02;
    tick();
    check_eq("held_wait", 32'(bus.din_ready), 32'd0);
    run_frame(8'h01, 1'b0, -1, 1'b1);
    run_frame(8'h02, 1'b0, -1, 1'b0);

    // Period lock.
    do_reset(1'b0);
    tick();
    edge_gap(256);
    edge_gap(256);
    check_eq("lock_after_e2", 32'(bus.lock), 32'd0);
    edge_gap(256);
    check_eq("lock_after_e3", 32'(bus.lock), 32'd1);
    edge_gap(255);
    check_eq("lock_hold_e4", 32'(bus.lock), 32'd1);
    edge_gap(256);
    check_eq("lock_lost_255", 32'(bus.lock), 32'd0);
    edge_gap(256);
    check_eq("lock_after_one_good", 32'(bus.lock), 32'd0);
    edge_gap(20);
    check_eq("lock_regained", 32'(bus.lock), 32'd1);

    // Reset mid-frame at bit 3.
    write_word(8'hF0);
    bus.strb = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 1) bus.strb = 1'b0;
    end
    check_eq("pre_abort_sdo_en", 32'(bus.sdo_en), 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("abort_sdo", 32'(bus.sdo), 32'd0);
    check_eq("abort_sdo_en", 32'(bus.sdo_en), 32'd0);
    check_eq("abort_ready", 32'(bus.din_ready), 32'd1);
    check_eq("abort_lock", 32'(bus.lock), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check_eq("abort_no_resume", 32'(bus.sdo_en), 32'd0);
    write_word(8'h96);
    run_frame(8'h96, 1'b0, -1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/frame_tx.md
FRAME_TX -- requirements
Module: frame_tx

Interface
REQ-001 Parameter FRAME_LEN, default 256: expected clocks between consecutive strb rising edges.
REQ-002 Parameter DATA_W, default 8: payload width in bits.
REQ-003 clk  input  1  single system clock; all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 strb  input  1  frame strobe from the frame-strobe generator; high for several clocks once per frame.
REQ-006 din  input  DATA_W  payload word for the next frame.
REQ-007 din_valid  input  1  din holds a valid word.
REQ-008 din_ready  output  1  holding register empty; word accepted when din_valid & din_ready.
REQ-009 sdo  output  1  serial data, MSB first.
REQ-010 sdo_en  output  1  high while sdo carries a frame bit.
REQ-011 underrun  output  1  one-clock pulse: frame started with holding register empty.
REQ-012 frame_err  output  1  one-clock pulse: strb rising edge while a frame is still shifting.
REQ-013 lock  output  1  strobe period verified equal to FRAME_LEN.

Function
REQ-014 strb is registered once (strb_d); frame start is strb & ~strb_d; strb level beyond the edge is ignored.
REQ-015 The holding register loads din on the din_valid & din_ready clock; din_ready = ~hold_full.
REQ-016 FSM states: IDLE, SHIFT (plus PAR under FRAME_PARITY_EN); reset state IDLE.
REQ-017 IDLE -> SHIFT on frame start; the shifter loads hold (hold_full clears the same clock) or 0 when hold is empty.
REQ-018 Frame start with hold empty shifts all-zero payload and pulses underrun on the clock after the edge.
REQ-019 Latency: the first payload bit (bit DATA_W-1) appears on sdo with sdo_en=1 on the clock after the frame-start clock.
REQ-020 SHIFT holds for exactly DATA_W clocks, one bit per clock, then -> IDLE (or PAR); sdo=0 and sdo_en=0 in IDLE.
REQ-021 A frame start while in SHIFT/PAR is ignored (shifting continues unchanged) and pulses frame_err for one clock.
REQ-022 A word accepted into hold on the same clock as a frame-start load is impossible (din_ready=0 when full); a word offered while hold empties is accepted the clock after.
REQ-023 Period counter, 16 bits, clears to 1 at each frame start, increments otherwise, saturates at 16'hFFFF.
REQ-024 At each frame start except the first after reset, counter value == FRAME_LEN increments a 2-bit good count (saturating at 2); mismatch clears good count and lock.
REQ-025 lock = 1 from the clock after good count reaches 2; stays until a mismatching period or reset.
REQ-026 lock does not gate transmission; frames are sent whether locked or not.

Reset
REQ-027 rst_n low asynchronously forces: FSM IDLE, hold empty, shifter 0, strb_d 0, counter 0, good count 0, first-edge flag set.
REQ-028 Reset outputs: din_ready=1, sdo=0, sdo_en=0, underrun=0, frame_err=0, lock=0.
REQ-029 Reset mid-frame aborts the frame immediately; no partial bits resume after release.
REQ-030 A strb already high when rst_n releases is not a frame start (strb_d samples it first).

Configuration
REQ-031 Macro FRAME_PARITY_EN defined: after the last payload bit, state PAR drives one even-parity bit (XOR of payload) with sdo_en=1, then IDLE; frame is DATA_W+1 bits.
REQ-032 FRAME_PARITY_EN undefined: no PAR state, no parity logic, frame is exactly DATA_W bits.

Verification
REQ-033 Write din=8'hA5, then strb rise -> sdo 1,0,1,0,0,1,0,1 on 8 consecutive clocks starting 1 clock after edge, sdo_en high exactly 8 clocks (9, last bit 0, with FRAME_PARITY_EN).
REQ-034 Strb rise with no word written -> sdo_en 8 clocks of sdo=0, underrun pulse 1 clock after edge.
REQ-035 Strb edges every 256 clocks x4 -> lock=1 after third edge; one period of 255 -> lock=0; two more 256 periods -> lock=1.
REQ-036 Second strb rise 4 clocks into a frame -> frame_err one pulse, transmitted bits unchanged.
REQ-037 rst_n low at bit 3 of a frame -> sdo/sdo_en=0 immediately, din_ready=1, lock=0; next strb rise sends a fresh frame.
REQ-038 din_valid held high across frames with words 8'h01,8'h02 -> din_ready drops after first accept, word 2 accepted the clock after frame 1 loads, frames carry 01 then 02.
